// File: rtl/gps_spi_streamer.sv
`default_nettype none
// ============================================================================
// gps_spi_streamer : packs GPS I/Q sample sets into words, queues them in a
// FIFO and streams them out as an SPI mode-0 master (MSB first, active-low SS).
// Optional macro GPS_SPI_STREAMER_TEST_PATTERN_EN adds a counting test pattern.
// Revision: 1.0
// ============================================================================
module gps_spi_streamer #(
  parameter int SAMPLE_W   = 2,
  parameter int NUM_CH     = 2,
  parameter int WORD_W     = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int SCK_DIV    = 2,
  parameter int SS_GAP     = 2
) (
  input  logic                           mcu_clk_25_000_i,
  input  logic                           reset_n_i,
  input  logic [SAMPLE_W*NUM_CH-1:0]     sample_in_i,
  input  logic                           sample_valid_i,
  input  logic                           enable_i,
  input  logic                           ovf_clr_i,
`ifdef GPS_SPI_STREAMER_TEST_PATTERN_EN
  input  logic                           test_mode_i,
`endif
  output logic                           mcu_sck_o,
  output logic                           mcu_ss_o,
  output logic                           mcu_mosi_o,
  output logic                           overflow_o,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_level_o
);

  localparam int SET_W = SAMPLE_W * NUM_CH;
  localparam int K     = WORD_W / SET_W;
  localparam int CNT_W = $clog2(K + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int BIT_W = $clog2(WORD_W);
  localparam int DIV_W = $clog2(SCK_DIV + 1);
  localparam int GAP_W = $clog2(SS_GAP + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, GAP = 2'd2} state_t;

  logic                clk;
  logic                rst_n;
  assign clk   = mcu_clk_25_000_i;
  assign rst_n = reset_n_i;

  // ---------------- packer ----------------
  logic [CNT_W-1:0]  set_cnt_q;
  logic [WORD_W-1:0] pack_q;
  logic [WORD_W-1:0] pack_d;
  logic [WORD_W-1:0] word_q;
  logic [WORD_W-1:0] word_d;
  logic              push_q;
  logic              accept;
  logic              last_set;

  assign accept   = sample_valid_i && enable_i;
  assign last_set = (set_cnt_q == CNT_W'(K - 1));
  // Shift-in packing: after K sets the first one has reached the MSBs.
  assign pack_d   = WORD_W'({pack_q, sample_in_i});

`ifdef GPS_SPI_STREAMER_TEST_PATTERN_EN
  logic [WORD_W-1:0] pat_q;
  assign word_d = test_mode_i ? pat_q : pack_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pat_q <= '0;
    end else if (accept && last_set) begin
      pat_q <= pat_q + WORD_W'(1);
    end
  end
`else
  assign word_d = pack_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      set_cnt_q <= '0;
      pack_q    <= '0;
      word_q    <= '0;
      push_q    <= 1'b0;
    end else begin
      push_q <= accept && last_set;
      if (!enable_i) begin
        set_cnt_q <= '0;
      end else if (sample_valid_i) begin
        pack_q <= pack_d;
        if (last_set) begin
          set_cnt_q <= '0;
          word_q    <= word_d;
        end else begin
          set_cnt_q <= set_cnt_q + CNT_W'(1);
        end
      end
    end
  end

  // ---------------- word FIFO ----------------
  logic [WORD_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [LVL_W-1:0]  level_q;
  logic              overflow_q;
  logic              full;
  logic              pop;
  logic              wr_en;
  state_t            state_q;

  assign full  = (level_q == LVL_W'(FIFO_DEPTH));
  assign pop   = (state_q == IDLE) && (level_q != '0);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign wr_en = push_q && (!full || pop);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= word_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({wr_en, pop})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
      if (push_q && full && !pop) begin
        overflow_q <= 1'b1;
      end else if (ovf_clr_i) begin
        overflow_q <= 1'b0;
      end
    end
  end

  // ---------------- SPI master ----------------
  logic [WORD_W-1:0] sr_q;
  logic [BIT_W-1:0]  bit_q;
  logic [DIV_W-1:0]  div_q;
  logic [GAP_W-1:0]  gap_q;
  logic              sck_q;
  logic              ss_q;
  logic              mosi_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      bit_q   <= '0;
      div_q   <= '0;
      gap_q   <= '0;
      sck_q   <= 1'b0;
      ss_q    <= 1'b1;
      mosi_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          sck_q <= 1'b0;
          ss_q  <= 1'b1;
          if (pop) begin
            sr_q    <= mem_q[rd_ptr_q];
            mosi_q  <= mem_q[rd_ptr_q][WORD_W-1];
            ss_q    <= 1'b0;
            div_q   <= '0;
            bit_q   <= '0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (div_q == DIV_W'(SCK_DIV - 1)) begin
            div_q <= '0;
            if (!sck_q) begin
              sck_q <= 1'b1;
            end else begin
              sck_q <= 1'b0;
              // The last falling edge of SCK is also the SS release edge.
              if (bit_q == BIT_W'(WORD_W - 1)) begin
                ss_q    <= 1'b1;
                mosi_q  <= 1'b0;
                gap_q   <= '0;
                state_q <= GAP;
              end else begin
                bit_q  <= bit_q + BIT_W'(1);
                sr_q   <= sr_q << 1;
                mosi_q <= sr_q[WORD_W-2];
              end
            end
          end else begin
            div_q <= div_q + DIV_W'(1);
          end
        end
        GAP: begin
          if (gap_q == GAP_W'(SS_GAP - 1)) begin
            state_q <= IDLE;
          end else begin
            gap_q <= gap_q + GAP_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mcu_sck_o    = sck_q;
  assign mcu_ss_o     = ss_q;
  assign mcu_mosi_o   = mosi_q;
  assign overflow_o   = overflow_q;
  assign fifo_level_o = level_q;

endmodule
`default_nettype wire

// File: tb/tb_gps_spi_streamer.sv
`default_nettype none
// ============================================================================
// tb_gps_spi_streamer : scoreboard bench; a sample-level model queues expected
// words and an SPI monitor decodes MOSI frames and compares them.
// Revision: 1.0
// ============================================================================
module tb_gps_spi_streamer;

  localparam int SAMPLE_W   = 2;
  localparam int NUM_CH     = 2;
  localparam int WORD_W     = 16;
  localparam int FIFO_DEPTH = 8;
  localparam int SCK_DIV    = 2;
  localparam int SS_GAP     = 2;
  localparam int SET_W      = SAMPLE_W * NUM_CH;
  localparam int K          = WORD_W / SET_W;

  logic        clk          = 1'b0;
  logic        rst_n        = 1'b0;
  logic [3:0]  sample_in    = '0;
  logic        sample_valid = 1'b0;
  logic        enable       = 1'b0;
  logic        ovf_clr      = 1'b0;
  logic        test_mode    = 1'b0;
  logic        sck;
  logic        ss;
  logic        mosi;
  logic        overflow;
  logic [3:0]  level;

  int          vectors     = 0;
  int          miscompares = 0;
  logic [15:0] exp_q[$];
  logic [3:0]  model_sets[$];
  logic [15:0] model_pat   = '0;
  bit          model_drop  = 1'b0;
  int          last_gap    = 0;
  int          words_seen  = 0;
  logic [15:0] last_word   = '0;

  gps_spi_streamer #(
    .SAMPLE_W(SAMPLE_W), .NUM_CH(NUM_CH), .WORD_W(WORD_W),
    .FIFO_DEPTH(FIFO_DEPTH), .SCK_DIV(SCK_DIV), .SS_GAP(SS_GAP)
  ) dut (
    .mcu_clk_25_000_i(clk),
    .reset_n_i       (rst_n),
    .sample_in_i     (sample_in),
    .sample_valid_i  (sample_valid),
    .enable_i        (enable),
    .ovf_clr_i       (ovf_clr),
`ifdef GPS_SPI_STREAMER_TEST_PATTERN_EN
    .test_mode_i     (test_mode),
`endif
    .mcu_sck_o       (sck),
    .mcu_ss_o        (ss),
    .mcu_mosi_o      (mosi),
    .overflow_o      (overflow),
    .fifo_level_o    (level)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: collect accepted sets, first set ends up most significant.
  task automatic model_accept(input logic [3:0] s);
    model_sets.push_back(s);
    if (model_sets.size() == K) begin
      logic [15:0] w;
      w = '0;
      for (int i = 0; i < K; i++) w = (w << SET_W) | 16'(model_sets[i]);
      if (test_mode) w = model_pat;
      model_pat = model_pat + 16'd1;
      if (!model_drop) exp_q.push_back(w);
      model_sets.delete();
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [3:0] s);
    sample_in    = s;
    sample_valid = 1'b1;
    if (enable) model_accept(s);
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic set_enable(input logic v);
    enable = v;
    if (!v) model_sets.delete();
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    sample_valid = 1'b0;
    enable       = 1'b0;
    ovf_clr      = 1'b0;
    exp_q.delete();
    model_sets.delete();
    model_pat    = '0;
    model_drop   = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !ss || level != 0) && n < 3000) begin
      tick();
      n++;
    end
    check({name, "_drain_timeout"}, 32'(n >= 3000), 32'd0);
  endtask

  // SPI monitor: decode each SS-low frame and score it.
  logic        prev_ss  = 1'b1;
  logic        prev_sck = 1'b0;
  logic        in_word  = 1'b0;
  logic [15:0] shreg    = '0;
  int          nbits    = 0;
  int          lowcnt   = 0;
  int          highcnt  = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_word = 1'b0;
      highcnt = 0;
    end else begin
      if (!ss && prev_ss) begin
        in_word  = 1'b1;
        nbits    = 0;
        lowcnt   = 0;
        shreg    = '0;
        last_gap = highcnt;
      end
      if (!ss) begin
        lowcnt++;
        if (sck && !prev_sck) begin
          shreg = {shreg[14:0], mosi};
          nbits++;
        end
      end else begin
        if (!prev_ss) highcnt = 1;
        else highcnt++;
        if (!prev_ss && in_word) begin
          check("ss_low_cycles", 32'(lowcnt), 32'd64);
          check("sck_rises", 32'(nbits), 32'd16);
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_word: got 0x%0h required no word", shreg);
          end else begin
            check("mosi_word", 32'(shreg), 32'(exp_q.pop_front()));
          end
          last_word = shreg;
          words_seen++;
          in_word = 1'b0;
        end
      end
    end
    prev_ss  = ss;
    prev_sck = sck;
  end

  initial begin
    int n;
    int seen0;
    int rises;
    logic p;

    do_reset();
    check("reset_ss", 32'(ss), 32'd1);
    check("reset_sck", 32'(sck), 32'd0);
    check("reset_mosi", 32'(mosi), 32'd0);
    check("reset_overflow", 32'(overflow), 32'd0);
    check("reset_level", 32'(level), 32'd0);

`ifdef GPS_SPI_STREAMER_TEST_PATTERN_EN
    test_mode = 1'b1;
    set_enable(1'b1);
    for (int i = 0; i < 12; i++) strobe(4'($urandom));
    drain("test_pattern");
    test_mode = 1'b0;
`endif

    // Known word 0xD296.
    set_enable(1'b1);
    strobe(4'hD); strobe(4'h2); strobe(4'h9); strobe(4'h6);
    drain("d296");
    check("d296_word", 32'(last_word), 32'h0000_D296);

    // Back-to-back words: SS high for SS_GAP+1 cycles between them.
    for (int i = 0; i < 2 * K; i++) strobe(4'($urandom));
    drain("b2b");
    check("ss_gap", 32'(last_gap), 32'(SS_GAP + 1));

    // ENABLE low for one cycle discards the partial word and ignores a strobe.
    seen0 = words_seen;
    strobe(4'($urandom)); strobe(4'($urandom));
    set_enable(1'b0);
    strobe(4'($urandom));
    set_enable(1'b1);
    for (int i = 0; i < K; i++) strobe(4'($urandom));
    drain("enable");
    check("enable_word_count", 32'(words_seen - seen0), 32'd1);

    // Overflow: keep SPI busy with one word, then push 10 more.
    seen0 = words_seen;
    for (int i = 0; i < K; i++) strobe(4'($urandom));
    n = 0;
    while (ss && n < 50) begin tick(); n++; end
    check("ovf_wait_ss_timeout", 32'(n >= 50), 32'd0);
    for (int i = 0; i < 10 * K; i++) begin
      if (i == FIFO_DEPTH * K) model_drop = 1'b1;
      strobe(4'($urandom));
    end
    tick(); tick();
    check("ovf_level_full", 32'(level), 32'(FIFO_DEPTH));
    check("ovf_flag_set", 32'(overflow), 32'd1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_flag_cleared", 32'(overflow), 32'd0);
    model_drop = 1'b0;
    drain("overflow");
    check("ovf_words_out", 32'(words_seen - seen0), 32'(FIFO_DEPTH + 1));

    // Randomized traffic, slow enough on average that nothing is dropped.
    for (int i = 0; i < 160; i++) begin
      repeat ($urandom_range(40, 15)) tick();
      if ($urandom_range(15, 0) == 0) begin
        set_enable(1'b0);
        tick();
        set_enable(1'b1);
      end
      strobe(4'($urandom));
    end
    drain("random");
    check("random_no_overflow", 32'(overflow), 32'd0);

    // Reset at the 7th SCK rise with a second word waiting in the FIFO.
    for (int i = 0; i < 2 * K; i++) strobe(4'($urandom));
    rises = 0;
    n     = 0;
    p     = sck;
    while (rises < 7 && n < 500) begin
      tick();
      if (sck && !p) rises++;
      p = sck;
      n++;
    end
    check("rst_wait_sck_timeout", 32'(n >= 500), 32'd0);
    check("rst_pre_level", 32'(level), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_ss", 32'(ss), 32'd1);
    check("rst_mid_sck", 32'(sck), 32'd0);
    check("rst_mid_level", 32'(level), 32'd0);
    seen0 = words_seen;
    do_reset();
    repeat (200) tick();
    check("rst_no_resume", 32'(words_seen - seen0), 32'd0);

    // Recovery after reset.
    set_enable(1'b1);
    for (int i = 0; i < K; i++) strobe(4'($urandom));
    drain("post_reset");
    check("post_reset_words", 32'(words_seen - seen0), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gps_spi_streamer.md
GPS_SPI_STREAMER -- requirements
Module: gps_spi_streamer

Interface
REQ-001 Parameter SAMPLE_W, 2, bits per channel per sample (sign, magnitude).
REQ-002 Parameter NUM_CH, 2, channels per sample set (I, Q).
REQ-003 Parameter WORD_W, 16, SPI word width; SHALL be an integer multiple of SAMPLE_W*NUM_CH.
REQ-004 Parameter FIFO_DEPTH, 8, word FIFO depth; SHALL be a power of two, at least 2.
REQ-005 Parameter SCK_DIV, 2, MCU_SCK half-period in clock cycles, at least 1.
REQ-006 Parameter SS_GAP, 2, cycles MCU_SS is held high between words, at least 1.
REQ-007 MCU_CLK_25_000  in  1  sole clock; all logic on its rising edge.
REQ-008 RESET_N  in  1  asynchronous, active-low reset.
REQ-009 SAMPLE_IN  in  SAMPLE_W*NUM_CH  one sample set, already synchronous to the clock; channel NUM_CH-1 in the MSBs.
REQ-010 SAMPLE_VALID  in  1  one-cycle strobe qualifying SAMPLE_IN.
REQ-011 ENABLE  in  1  high = accept samples.
REQ-012 OVF_CLR  in  1  synchronous clear of OVERFLOW.
REQ-013 MCU_SCK / MCU_SS / MCU_MOSI  out  1 each  SPI master, mode 0, active-low SS.
REQ-014 OVERFLOW  out  1  sticky dropped-word flag.
REQ-015 FIFO_LEVEL  out  clog2(FIFO_DEPTH)+1  registered count of words held.

Function
REQ-016 Packer: K = WORD_W/(SAMPLE_W*NUM_CH) sets per word; first accepted set in the MSBs; the K-th accepted set completes the word, which is pushed to the FIFO on the next edge.
REQ-017 SAMPLE_VALID while ENABLE is low SHALL be ignored; ENABLE falling SHALL discard any partial word (set count = 0).
REQ-018 Push while FIFO full and no pop in the same cycle: word dropped, OVERFLOW set on the next edge.
REQ-019 Simultaneous push and pop when full: both performed, no overflow, FIFO_LEVEL unchanged.
REQ-020 FIFO pointers SHALL wrap modulo FIFO_DEPTH; FIFO_LEVEL SHALL equal FIFO_DEPTH when full.
REQ-021 OVERFLOW cleared by OVF_CLR; a same-cycle overflow event SHALL win (flag stays 1).
REQ-022 SPI FSM states: IDLE, SHIFT, GAP.
REQ-023 IDLE: SS=1, SCK=0; if FIFO non-empty, pop and load the shift register, then enter SHIFT on the next edge with SS=0 and MOSI = word MSB.
REQ-024 SHIFT: SCK rises SCK_DIV cycles after SS falls, period 2*SCK_DIV; MOSI updates to the next bit on each SCK fall; MSB first.
REQ-025 The WORD_W-th SCK fall SHALL coincide with SS rising; then enter GAP.
REQ-026 GAP: SS=1 for SS_GAP cycles, then IDLE; word-to-word period = 2*SCK_DIV*WORD_W + SS_GAP + 1 cycles.
REQ-027 ENABLE SHALL NOT affect the SPI FSM; the FIFO keeps draining while ENABLE is low.

Reset
REQ-028 RESET_N low: MCU_SS=1, MCU_SCK=0, MCU_MOSI=0, OVERFLOW=0, FIFO_LEVEL=0; FSM in IDLE; packer count 0; FIFO empty.
REQ-029 Reset mid-word SHALL abort the transfer immediately; no partial word is resumed after release.

Configuration
REQ-030 Macro GPS_SPI_STREAMER_TEST_PATTERN_EN defined: adds input TEST_MODE (1 bit); while it is high, each completed word SHALL be a WORD_W-bit counter (0, 1, 2, ..., wrapping) instead of packed samples, with the counter reset to 0 by RESET_N and advanced once per K accepted strobes.
REQ-031 Macro undefined: no TEST_MODE port and no counter logic.

Verification (defaults unless stated)
REQ-032 Four strobes with SAMPLE_IN 2'b11,2'b00,2'b10,2'b01 as 4-bit sets 0xD,0x2,0x9,0x6 -> MOSI word 0xD296, MSB first, 16 SCK rises, SS low for exactly 64 cycles.
REQ-033 Back-to-back words -> SS high exactly 3 cycles between words (SS_GAP+1).
REQ-034 Hold SPI busy and push 10 words -> FIFO_LEVEL reaches 8, OVERFLOW=1; pulse OVF_CLR -> 0; only the first 8 words appear on MOSI.
REQ-035 Two strobes, ENABLE low for 1 cycle, then four strobes -> single word formed from the last four sets only.
REQ-036 RESET_N low at the 7th SCK rise -> SS=1 and SCK=0 immediately; FIFO_LEVEL=0.
REQ-037 With GPS_SPI_STREAMER_TEST_PATTERN_EN and TEST_MODE=1, 12 strobes -> words 0x0000, 0x0001, 0x0002.
